// File: rtl/parity_frame_collector_if.sv
// Handshake bundle for parity_frame_collector: the lane sample input, flush,
// the frame result output with valid/ready, and the frame/drop statistics.
interface parity_frame_collector_if #(
   parameter int LANES = 8,
   parameter int FRAME = 4,
   parameter int CNT_W = 16
);
   localparam int ONES_W = $clog2(LANES*FRAME+1);

   logic [LANES-1:0]  in_vec;
   logic              in_valid;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [LANES-1:0]  out_sig;
   logic [ONES_W-1:0] out_ones;
   logic [CNT_W-1:0]  frame_cnt;
   logic [7:0]        drop_cnt;

   modport master (
      output in_vec, in_valid, flush, out_ready,
      input  out_valid, out_sig, out_ones, frame_cnt, drop_cnt
   );

   modport slave (
      input  in_vec, in_valid, flush, out_ready,
      output out_valid, out_sig, out_ones, frame_cnt, drop_cnt
   );
endinterface

// File: rtl/parity_frame_collector.sv
// Groups FRAME lane-parity samples into XOR signature + ones count frames.
// Define PARITY_FRAME_COLLECTOR_DROP_CNT_EN to build the saturating drop counter.
module parity_frame_collector #(
   parameter int LANES = 8,
   parameter int FRAME = 4,
   parameter int CNT_W = 16
) (
   input logic                     clk,
   input logic                     rst,
   parity_frame_collector_if.slave bus
);
   localparam int ONES_W = $clog2(LANES*FRAME+1);
   localparam int CW     = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME-1);

   typedef enum logic {COLLECT, HOLD} state_t;

   function automatic logic [ONES_W-1:0] popcount(input logic [LANES-1:0] v);
      logic [ONES_W-1:0] s;
      s = '0;
      for (int i = 0; i < LANES; i++) s = s + ONES_W'(v[i]);
      return s;
   endfunction

   state_t            state_q;
   logic [CW-1:0]     cnt_p0;
   logic [LANES-1:0]  acc_sig_p0;
   logic [ONES_W-1:0] acc_ones_p0;
   logic              vld_p1;
   logic [LANES-1:0]  out_sig_p1;
   logic [ONES_W-1:0] out_ones_p1;
   logic [CNT_W-1:0]  frame_cnt_q;

   logic              accept;
   logic              last;
   logic              handshake;
   logic [ONES_W-1:0] pop_in;

   // A held result blocks intake unless it is being consumed this very cycle.
   assign accept    = bus.in_valid && !bus.flush && (state_q == COLLECT || bus.out_ready);
   assign last      = (cnt_p0 == LAST);
   assign handshake = vld_p1 && bus.out_ready;
   assign pop_in    = popcount(bus.in_vec);

   // Stage p0: accumulate samples; stage p1: registered frame result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= COLLECT;
         cnt_p0      <= '0;
         acc_sig_p0  <= '0;
         acc_ones_p0 <= '0;
         vld_p1      <= 1'b0;
         out_sig_p1  <= '0;
         out_ones_p1 <= '0;
         frame_cnt_q <= '0;
      end else begin
         if (bus.flush || (accept && last)) begin
            cnt_p0      <= '0;
            acc_sig_p0  <= '0;
            acc_ones_p0 <= '0;
         end else if (accept) begin
            cnt_p0      <= cnt_p0 + CW'(1);
            acc_sig_p0  <= acc_sig_p0 ^ bus.in_vec;
            acc_ones_p0 <= acc_ones_p0 + pop_in;
         end

         // A completing sample takes priority so back-to-back frames never bubble.
         if (accept && last) begin
            out_sig_p1  <= acc_sig_p0 ^ bus.in_vec;
            out_ones_p1 <= acc_ones_p0 + pop_in;
            vld_p1      <= 1'b1;
            state_q     <= HOLD;
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
         end else if (handshake) begin
            vld_p1  <= 1'b0;
            state_q <= COLLECT;
         end
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_sig   = out_sig_p1;
   assign bus.out_ones  = out_ones_p1;
   assign bus.frame_cnt = frame_cnt_q;

`ifdef PARITY_FRAME_COLLECTOR_DROP_CNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   logic [7:0] drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= 8'h00;
      end else if (state_q == HOLD && !bus.out_ready && bus.in_valid && !bus.flush) begin
         drop_q <= sat_inc8(drop_q);
      end
   end

   assign bus.drop_cnt = drop_q;
`else
   assign bus.drop_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_parity_frame_collector.sv
// Directed bench for parity_frame_collector: a FRAME=4 instance and a FRAME=1
// instance, hand-computed signatures, ones counts and statistics.
module tb_parity_frame_collector;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   parity_frame_collector_if #(.LANES(8), .FRAME(4), .CNT_W(16)) ia ();
   parity_frame_collector_if #(.LANES(8), .FRAME(1), .CNT_W(16)) ib ();

   parity_frame_collector #(.LANES(8), .FRAME(4), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .bus(ia.slave));
   parity_frame_collector #(.LANES(8), .FRAME(1), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .bus(ib.slave));

`ifdef PARITY_FRAME_COLLECTOR_DROP_CNT_EN
   localparam bit DROP_ON = 1'b1;
`else
   localparam bit DROP_ON = 1'b0;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int exp_drop;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [7:0] v);
      ia.in_vec   = v;
      ia.in_valid = 1'b1;
      cyc();
      ia.in_valid = 1'b0;
   endtask

   task automatic chk_a(input string tag, input logic v, input logic [7:0] sig,
                        input int ones, input int fc);
      check_val({tag, ".valid"}, 32'(ia.out_valid), 32'(v));
      check_val({tag, ".sig"},   32'(ia.out_sig),   32'(sig));
      check_val({tag, ".ones"},  32'(ia.out_ones),  32'(ones));
      check_val({tag, ".fcnt"},  32'(ia.frame_cnt), 32'(fc));
   endtask

   initial begin
      rst = 1'b1;
      ia.in_vec = '0; ia.in_valid = 1'b0; ia.flush = 1'b0; ia.out_ready = 1'b0;
      ib.in_vec = '0; ib.in_valid = 1'b0; ib.flush = 1'b0; ib.out_ready = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;

      chk_a("reset_a", 1'b0, 8'h00, 0, 0);
      check_val("reset_a.drop", 32'(ia.drop_cnt), 32'd0);
      check_val("reset_b.valid", 32'(ib.out_valid), 32'd0);
      check_val("reset_b.fcnt", 32'(ib.frame_cnt), 32'd0);

      // FRAME=1: every sample is a frame, result follows input by one cycle.
      ib.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ib.in_vec   = (k % 2 == 1) ? 8'h41 : 8'h07;
         ib.in_valid = 1'b1;
         cyc();
         check_val("f1.valid", 32'(ib.out_valid), 32'd1);
         check_val("f1.sig",   32'(ib.out_sig),   (k % 2 == 1) ? 32'h41 : 32'h07);
         check_val("f1.ones",  32'(ib.out_ones),  (k % 2 == 1) ? 32'd2 : 32'd3);
         check_val("f1.fcnt",  32'(ib.frame_cnt), 32'(k + 1));
      end
      ib.in_valid = 1'b0;
      cyc();
      check_val("f1.release", 32'(ib.out_valid), 32'd0);

      // Basic frame with ready high.
      ia.out_ready = 1'b1;
      send_a(8'h07); send_a(8'h41); send_a(8'h07);
      check_val("t1.early", 32'(ia.out_valid), 32'd0);
      send_a(8'h41);
      chk_a("t1", 1'b1, 8'h00, 10, 1);
      cyc();
      check_val("t1.release", 32'(ia.out_valid), 32'd0);

      // Held result, samples during hold are dropped.
      ia.out_ready = 1'b0;
      send_a(8'h07); send_a(8'h41); send_a(8'hFF); send_a(8'h00);
      chk_a("t2", 1'b1, 8'hB9, 13, 2);
      send_a(8'hFF); send_a(8'hFF); send_a(8'hFF);
      chk_a("t2.hold", 1'b1, 8'hB9, 13, 2);
      exp_drop = DROP_ON ? 3 : 0;
      check_val("t2.drop", 32'(ia.drop_cnt), 32'(exp_drop));
      ia.out_ready = 1'b1;
      cyc();
      check_val("t2.release", 32'(ia.out_valid), 32'd0);

      // Sample on the handshake cycle starts the next frame.
      ia.out_ready = 1'b0;
      send_a(8'h01); send_a(8'h02); send_a(8'h04); send_a(8'h08);
      chk_a("t3a", 1'b1, 8'h0F, 4, 3);
      ia.out_ready = 1'b1;
      send_a(8'hFF);
      check_val("t3.hs_valid", 32'(ia.out_valid), 32'd0);
      send_a(8'h00); send_a(8'h00);
      check_val("t3.mid_valid", 32'(ia.out_valid), 32'd0);
      send_a(8'h00);
      chk_a("t3b", 1'b1, 8'hFF, 8, 4);
      cyc();
      check_val("t3.release", 32'(ia.out_valid), 32'd0);

      // Flush discards a partial frame; flush with in_valid is not a drop.
      ia.out_ready = 1'b0;
      send_a(8'h03); send_a(8'h05);
      ia.flush = 1'b1;
      send_a(8'hFF);
      ia.flush = 1'b0;
      send_a(8'h01); send_a(8'h01); send_a(8'h01);
      check_val("t5.early", 32'(ia.out_valid), 32'd0);
      send_a(8'h01);
      chk_a("t5", 1'b1, 8'h00, 4, 5);
      check_val("t5.drop", 32'(ia.drop_cnt), 32'(exp_drop));
      ia.flush = 1'b1;
      send_a(8'hAA);
      ia.flush = 1'b0;
      chk_a("t5.flush_hold", 1'b1, 8'h00, 4, 5);
      check_val("t5.flush_drop", 32'(ia.drop_cnt), 32'(exp_drop));

      // Drop counter saturation.
      for (int k = 0; k < 260; k++) send_a(8'h5A);
      check_val("sat.drop", 32'(ia.drop_cnt), DROP_ON ? 32'd255 : 32'd0);
      chk_a("sat.hold", 1'b1, 8'h00, 4, 5);

      // Reset mid-frame clears everything.
      ia.out_ready = 1'b1;
      cyc();
      check_val("t6.release", 32'(ia.out_valid), 32'd0);
      send_a(8'h01); send_a(8'h02);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk_a("t6.reset", 1'b0, 8'h00, 0, 0);
      check_val("t6.drop", 32'(ia.drop_cnt), 32'd0);
      send_a(8'h01); send_a(8'h02); send_a(8'h04);
      check_val("t6.early", 32'(ia.out_valid), 32'd0);
      send_a(8'h08);
      chk_a("t6.frame", 1'b1, 8'h0F, 4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
